silife_spi_slave: RTL and testbench

SILIFE_SPI_SLAVE -- requirements
Module: silife_spi_slave

---
 rtl/silife_spi_pkg.sv | 8 +
 rtl/silife_sync2.sv | 23 ++
 rtl/silife_spi_slave.sv | 103 ++++++++++
 tb/tb_silife_spi_slave.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/silife_spi_pkg.sv
// Shared constants for the silife SPI slave (word width, synchronizer depth).
package silife_spi_pkg;
   localparam int unsigned SPI_WORD_BITS = 16;
   localparam int unsigned SYNC_STAGES   = 2;
   localparam int unsigned CNT_BITS      = $clog2(SPI_WORD_BITS);

   typedef logic [SPI_WORD_BITS-1:0] spi_word_t;
endpackage

// File: rtl/silife_sync2.sv
// Multi-flop synchronizer for one asynchronous input bit, cleared by reset.
module silife_sync2
   import silife_spi_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/silife_spi_slave.sv
// Mode-0 SPI receive-only slave, 16-bit MSB-first words, oversampled on clk.
// Optional idle timeout on partial words: define SILIFE_SPI_SLAVE_TIMEOUT_EN.
module silife_spi_slave
   import silife_spi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_sck,
   input  logic                     i_mosi,
   input  logic                     i_cs_n,
   output logic [SPI_WORD_BITS-1:0] o_word,
   output logic                     o_valid,
   output logic                     o_frame_err,
   output logic                     o_busy
);

   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(SPI_WORD_BITS - 1);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic w_sck;
   logic w_mosi;
   logic w_cs_n;
   logic w_rise;

   logic                     r_sck_d;
   logic [CNT_BITS-1:0]      r_cnt;
   // The 16th bit never needs storing: it goes straight from mosi into o_word.
   logic [SPI_WORD_BITS-2:0] r_shift;
   spi_word_t                r_word;
   logic                     r_valid;
   logic                     r_frame_err;
   logic                     r_busy;

   silife_sync2 u_sync_sck  (.clk(clk), .reset(reset), .i_d(i_sck),  .o_q(w_sck));
   silife_sync2 u_sync_mosi (.clk(clk), .reset(reset), .i_d(i_mosi), .o_q(w_mosi));
   silife_sync2 u_sync_cs_n (.clk(clk), .reset(reset), .i_d(i_cs_n), .o_q(w_cs_n));

   assign w_rise = w_sck & ~r_sck_d;

`ifdef SILIFE_SPI_SLAVE_TIMEOUT_EN
   localparam int unsigned IDLE_BITS = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_BITS-1:0] IDLE_LAST = IDLE_BITS'(TIMEOUT_CYCLES - 1);
   logic [IDLE_BITS-1:0] r_idle;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sck_d     <= 1'b0;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_word      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
`ifdef SILIFE_SPI_SLAVE_TIMEOUT_EN
         r_idle      <= '0;
`endif
      end else begin
         r_sck_d     <= w_sck;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= (r_cnt != '0);
         if (w_cs_n) begin
            r_frame_err <= (r_cnt != '0);
            r_cnt       <= '0;
            r_shift     <= '0;
`ifdef SILIFE_SPI_SLAVE_TIMEOUT_EN
            r_idle      <= '0;
`endif
         end else if (w_rise) begin
            r_shift <= {r_shift[SPI_WORD_BITS-3:0], w_mosi};
            r_cnt   <= r_cnt + CNT_BITS'(1);
            if (r_cnt == LAST_BIT) begin
               r_word  <= {r_shift, w_mosi};
               r_valid <= 1'b1;
            end
`ifdef SILIFE_SPI_SLAVE_TIMEOUT_EN
            r_idle  <= '0;
         end else if (r_cnt != '0) begin
            if (r_idle == IDLE_LAST) begin
               r_cnt       <= '0;
               r_shift     <= '0;
               r_idle      <= '0;
               r_frame_err <= 1'b1;
            end else begin
               r_idle <= r_idle + IDLE_BITS'(1);
            end
`endif
         end
      end
   end

   assign o_word      = r_word;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_silife_spi_slave.sv
// Scoreboard bench for silife_spi_slave: stimulus pushes expected events, monitor pops.
`timescale 1ns/1ps
module tb_silife_spi_slave;

   logic        clk;
   logic        reset;
   logic        sck;
   logic        mosi;
   logic        cs_n;
   logic [15:0] o_word;
   logic        o_valid;
   logic        o_frame_err;
   logic        o_busy;

   typedef struct {
      bit          is_err;
      logic [15:0] word;
   } ev_t;

   ev_t q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   silife_spi_slave #(.TIMEOUT_CYCLES(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_sck       (sck),
      .i_mosi      (mosi),
      .i_cs_n      (cs_n),
      .o_word      (o_word),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         sck  = 1'b0;
         tick(4);
         sck  = 1'b1;
         tick(4);
      end
      sck = 1'b0;
   endtask

   task automatic expect_word(input logic [15:0] w);
      q.push_back('{1'b0, w});
   endtask

   task automatic expect_err();
      q.push_back('{1'b1, 16'h0000});
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      ev_t ev;
      if (!reset && (o_valid || o_frame_err)) begin
         if (q.size() == 0) begin
            check("unexpected_event", {30'b0, o_valid, o_frame_err}, 32'h0);
         end else begin
            ev = q.pop_front();
            check("event_kind", {31'b0, o_frame_err}, {31'b0, ev.is_err});
            check("event_single", {31'b0, o_valid & o_frame_err}, 32'h0);
            if (!ev.is_err) check("o_word", {16'b0, o_word}, {16'b0, ev.word});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      cs_n  = 1'b0;
      tick(5);
      check("rst_word",  {16'b0, o_word},    32'h0);
      check("rst_valid", {31'b0, o_valid},   32'h0);
      check("rst_err",   {31'b0, o_frame_err}, 32'h0);
      check("rst_busy",  {31'b0, o_busy},    32'h0);
      reset = 1'b0;
      tick(5);

      // single word
      expect_word(16'hA5C3);
      send_bits(16'hA5C3, 16);
      tick(10);
      check("busy_idle_after_word", {31'b0, o_busy}, 32'h0);

      // back-to-back words
      expect_word(16'h0001);
      send_bits(16'h0001, 16);
      expect_word(16'hFFFF);
      send_bits(16'hFFFF, 16);
      tick(10);

      // partial word aborted by cs_n
      send_bits(16'h0016, 5);
      tick(6);
      check("busy_partial", {31'b0, o_busy}, 32'h1);
      expect_err();
      cs_n = 1'b1;
      tick(8);
      cs_n = 1'b0;
      tick(6);
      expect_word(16'h1234);
      send_bits(16'h1234, 16);
      tick(10);

      // partial word followed by long idle
      send_bits(16'h0055, 7);
`ifdef SILIFE_SPI_SLAVE_TIMEOUT_EN
      expect_err();
      tick(70);
      check("busy_after_timeout", {31'b0, o_busy}, 32'h0);
      expect_word(16'hBEEF);
      send_bits(16'hBEEF, 16);
      tick(10);
      cs_n = 1'b1;
      tick(8);
`else
      tick(70);
      check("busy_persist", {31'b0, o_busy}, 32'h1);
      // 7 stale bits 1010101 + first 9 bits of 0xBEEF
      expect_word(16'hAB7D);
      send_bits(16'hBEEF, 16);
      tick(10);
      check("busy_leftover", {31'b0, o_busy}, 32'h1);
      expect_err();
      cs_n = 1'b1;
      tick(8);
`endif

      // SCK toggling while deselected
      for (int i = 0; i < 8; i++) begin
         sck = 1'b0;
         tick(4);
         sck = 1'b1;
         tick(4);
         check("busy_deselected", {31'b0, o_busy}, 32'h0);
      end
      sck  = 1'b0;
      cs_n = 1'b0;
      tick(6);

      // reset mid-word
      send_bits(16'h00FF, 8);
      tick(2);
      reset = 1'b1;
      tick(3);
      check("midrst_word",  {16'b0, o_word},      32'h0);
      check("midrst_valid", {31'b0, o_valid},     32'h0);
      check("midrst_err",   {31'b0, o_frame_err}, 32'h0);
      check("midrst_busy",  {31'b0, o_busy},      32'h0);
      reset = 1'b0;
      tick(5);
      expect_word(16'h00FF);
      send_bits(16'h00FF, 16);

      for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
      tick(10);
      check("queue_drained", q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
